wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage pipeline: it captures the retiring instruction from MEM, selects and formats the result, and drives the register file's write port from flops. It also republishes the write as a forwarding source for EX and keeps a retired-instruction counter. It sits between the MEM stage and `registers`, and is the only writer of the register file.

## Interface
- `CPU_WIDTH`, default 32: datapath width, from `riscv_define.v`.
- `REG_ADDR_WIDTH`, default 5: register address width, from `riscv_define.v`.
- `clk  in  1`: the single clock.
- `rstn  in  1`: reset, asynchronous and active-low.
- `in_valid  in  1`: MEM holds a real instruction.
- `stall  in  1`: hold the stage contents.
- `flush  in  1`: discard the incoming instruction.
- `in_rd_en  in  1`: the instruction writes rd.
- `in_rd_addr  in  REG_ADDR_WIDTH`: destination register.
- `in_wb_sel  in  2`: result source. 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved, treated as ALU.
- `in_alu_result  in  CPU_WIDTH`: ALU result.
- `in_load_data  in  CPU_WIDTH`: raw aligned memory word.
- `in_load_funct3  in  3`: load type.
- `in_addr_low  in  2`: byte offset of the load address.
- `in_pc_plus4  in  CPU_WIDTH`: link value.
- `write_en  out  1`, `write_addr  out  REG_ADDR_WIDTH`, `write_data  out  CPU_WIDTH`: register-file write port.
- `fwd_valid  out  1`, `fwd_addr  out  REG_ADDR_WIDTH`, `fwd_data  out  CPU_WIDTH`: forwarding source for EX.
- `retired  out  32`: count of retired instructions.

## Operation
- Result selection and load extension are combinational on the inputs, before the stage register. Every output is therefore a direct flop output. This is mandatory because `registers` writes combinationally, so `write_en` must be glitch-free.
- Load formatting by `in_load_funct3`:
  - 0 = LB: byte `in_addr_low[1:0]`, sign-extended.
  - 4 = LBU: same byte, zero-extended.
  - 1 = LH: half selected by `in_addr_low[1]`, sign-extended; `in_addr_low[0]` is ignored.
  - 5 = LHU: same half, zero-extended.
  - 2 = LW: whole word; `in_addr_low` is ignored.
  - 3, 6, 7: treated as LW.
- Stage register: `wb_valid`, `wb_we`, `wb_addr`, `wb_data`.
- Clock-edge update, in priority order:
  1. `flush=1`: `wb_valid`←0 and `wb_we`←0. Flush wins over stall.
  2. `stall=1`: all fields hold.
  3. Otherwise: `wb_valid`←`in_valid`; `wb_we`←`in_valid & in_rd_en & (in_rd_addr != 0)`; address and data load.
- `write_en` = `wb_we`. A write to x0 is never issued.
- `fwd_valid` = `wb_we`. `fwd_addr` and `fwd_data` mirror `write_addr` and `write_data`.
- Holding under stall re-presents the same write; this is idempotent at the register file.
- `retired` increments by 1 on every edge where `wb_valid=1` and (`stall=0` or `flush=1`), i.e. when the resident instruction leaves the stage. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values, applied asynchronously on `rstn` low: `wb_valid`=0, `write_en`=0, `write_addr`=0, `write_data`=0, `fwd_*`=0, `retired`=0.
- Latency is 1 cycle. An instruction presented with `stall=0` at edge N drives the write port during cycle N..N+1, and `registers` holds the value from that cycle.
- Throughput is one instruction per cycle with no bubbles inserted.
- Both `stall` and `flush` are sampled at the edge only.
- Reset mid-operation drops the in-flight write immediately: `write_en` falls asynchronously.
- With `flush` and `stall` asserted together, the resident instruction is counted as retired and the stage empties.
- Read-after-write in the same cycle is not resolved here. EX must use the `fwd_*` outputs.

## Structure
- Add to `riscv_define.v`:
  - `WB_SEL_ALU`, `WB_SEL_LOAD`, `WB_SEL_PC4`.
  - `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- One sub-module, `load_extend`: purely combinational, taking funct3, offset and word, and returning the formatted value.
- Top level holds the selection mux, the stage register and the retire counter.

## Test plan
- Reset release, then ALU op with `rd=5`, data 0x1234_5678 → next cycle `write_en=1`, `write_addr=5`, `write_data`=0x1234_5678, `retired`=1 after leaving the stage.
- Word 0x80FF_7F01 loaded with each offset and type:
  - LB off 0 → 0x0000_0001.
  - LB off 3 → 0xFFFF_FF80.
  - LBU off 2 → 0x0000_00FF.
  - LH off 2 → 0xFFFF_80FF.
  - LHU off 0 → 0x0000_7F01.
  - funct3=7 → 0x80FF_7F01.
- `rd=0` with `in_rd_en=1`, and `in_wb_sel`=10 with PC+4 = 0x104 to `rd=1` → no write for the first; second gives `write_data`=0x104.
- Stall held 3 cycles with a valid instruction resident → write held stable, `retired` increments once, on release.
- `flush` and `stall` together with a valid instruction incoming → `write_en`=0 next cycle, incoming discarded, resident counted.
- `retired` preloaded to 0xFFFF_FFFF, then one retirement → 0. Assert `rstn` low mid-write → `write_en` drops without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: result-source selectors and load funct3 codes.
package wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load formatter: picks the addressed byte/half from an aligned word
// and sign- or zero-extends it; unknown funct3 codes pass the whole word through.
module load_extend
  import wb_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   i_funct3,
  input  logic [1:0]   i_offset,
  input  logic [W-1:0] i_word,
  output logic [W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select from the byte offset
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension by load type
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{(W-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(W-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(W-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(W-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the retiring result, registers the register-file write port
// (mirrored as a forwarding source) and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [1:0]                in_wb_sel,
  input  logic [CPU_WIDTH-1:0]      in_alu_result,
  input  logic [CPU_WIDTH-1:0]      in_load_data,
  input  logic [2:0]                in_load_funct3,
  input  logic [1:0]                in_addr_low,
  input  logic [CPU_WIDTH-1:0]      in_pc_plus4,
  output logic                      write_en,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [CPU_WIDTH-1:0]      write_data,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [CPU_WIDTH-1:0]      fwd_data,
  output logic [31:0]               retired
);

  logic [CPU_WIDTH-1:0]      w_load_fmt;
  logic [CPU_WIDTH-1:0]      w_result;
  logic                      w_we_next;
  logic                      w_leave;

  logic                      r_valid;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic [CPU_WIDTH-1:0]      r_data;
  logic [31:0]               r_retired;

  load_extend #(.W(CPU_WIDTH)) u_load_extend (
    .i_funct3 (in_load_funct3),
    .i_offset (in_addr_low),
    .i_word   (in_load_data),
    .o_data   (w_load_fmt)
  );

  // Result mux; the reserved selector falls back to the ALU result
  always_comb begin
    w_result = in_alu_result;
    case (in_wb_sel)
      WB_SEL_LOAD: w_result = w_load_fmt;
      WB_SEL_PC4:  w_result = in_pc_plus4;
      default:     w_result = in_alu_result;
    endcase
  end

  assign w_we_next = in_valid & in_rd_en & (in_rd_addr != {REG_ADDR_WIDTH{1'b0}});
  assign w_leave   = r_valid & (~stall | flush);

  // Stage register: flush beats stall, stall holds everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= {REG_ADDR_WIDTH{1'b0}};
      r_data  <= {CPU_WIDTH{1'b0}};
    end else if (flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_we    <= w_we_next;
      r_addr  <= in_rd_addr;
      r_data  <= w_result;
    end
  end

  // Retire counter, advanced when the resident instruction leaves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_retired <= 32'd0;
    end else if (w_leave) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign write_en   = r_we;
  assign write_addr = r_addr;
  assign write_data = r_data;
  assign fwd_valid  = r_we;
  assign fwd_addr   = r_addr;
  assign fwd_data   = r_data;
  assign retired    = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan cases plus random traffic
// compared against a behavioural model of the stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, stall, flush, in_rd_en;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_load_data, in_pc_plus4;
  logic [2:0]  in_load_funct3;
  logic [1:0]  in_addr_low;
  logic        write_en, fwd_valid;
  logic [4:0]  write_addr, fwd_addr;
  logic [31:0] write_data, fwd_data, retired;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit          m_valid, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_ret;

  wb_stage dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .in_load_funct3(in_load_funct3), .in_addr_low(in_addr_low),
    .in_pc_plus4(in_pc_plus4), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_result();
    case (in_wb_sel)
      2'b01:   return ref_load(in_load_funct3, in_addr_low, in_load_data);
      2'b10:   return in_pc_plus4;
      default: return in_alu_result;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_ret = 32'd0;
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, ".write_en"},   {31'd0, write_en},  {31'd0, m_we});
    chk_eq({tag, ".write_addr"}, {27'd0, write_addr}, {27'd0, m_addr});
    chk_eq({tag, ".write_data"}, write_data, m_data);
    chk_eq({tag, ".fwd_valid"},  {31'd0, fwd_valid}, {31'd0, m_we});
    chk_eq({tag, ".fwd_addr"},   {27'd0, fwd_addr},   {27'd0, m_addr});
    chk_eq({tag, ".fwd_data"},   fwd_data, m_data);
    chk_eq({tag, ".retired"},    retired, m_ret);
  endtask

  // one clock edge: advance the model from the current inputs, then compare
  task automatic step(input string tag);
    if (m_valid && (!stall || flush)) m_ret = m_ret + 32'd1;
    if (flush) begin
      m_valid = 1'b0; m_we = 1'b0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_we    = in_valid && in_rd_en && (in_rd_addr != 5'd0);
      m_addr  = in_rd_addr;
      m_data  = ref_result();
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; in_rd_en = 1'b0;
    in_rd_addr = 5'd0; in_wb_sel = 2'b00; in_alu_result = 32'd0;
    in_load_data = 32'd0; in_load_funct3 = 3'd0; in_addr_low = 2'd0; in_pc_plus4 = 32'd0;
  endtask

  task automatic put(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                     input logic [31:0] ld, input logic [2:0] f3, input logic [1:0] off,
                     input logic [31:0] pc);
    in_valid = 1'b1; in_rd_en = 1'b1; in_rd_addr = rd; in_wb_sel = sel;
    in_alu_result = alu; in_load_data = ld; in_load_funct3 = f3;
    in_addr_low = off; in_pc_plus4 = pc;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
    put(5'd10, 2'b01, 32'hDEAD_BEEF, 32'h80FF_7F01, f3, off, 32'h0);
    step(tag);
    chk_eq({tag, ".const"}, write_data, exp);
  endtask

  initial begin
    logic [31:0] ret_before;
    idle();
    rstn = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    #1 rstn = 1'b1;

    put(5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 32'h0);
    step("alu");
    chk_eq("alu.en_const",   {31'd0, write_en}, 32'd1);
    chk_eq("alu.addr_const", {27'd0, write_addr}, 32'd5);
    chk_eq("alu.data_const", write_data, 32'h1234_5678);
    idle();
    step("alu_leave");
    chk_eq("alu.retired_const", retired, 32'd1);

    load_case("lb0",  3'd0, 2'd0, 32'h0000_0001);
    load_case("lb3",  3'd0, 2'd3, 32'hFFFF_FF80);
    load_case("lbu2", 3'd4, 2'd2, 32'h0000_00FF);
    load_case("lh2",  3'd1, 2'd2, 32'hFFFF_80FF);
    load_case("lhu0", 3'd5, 2'd0, 32'h0000_7F01);
    load_case("f3_7", 3'd7, 2'd1, 32'h80FF_7F01);

    put(5'd0, 2'b00, 32'hAAAA_5555, 32'h0, 3'd0, 2'd0, 32'h0);
    step("x0");
    chk_eq("x0.no_write", {31'd0, write_en}, 32'd0);
    put(5'd1, 2'b10, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0000_0104);
    step("pc4");
    chk_eq("pc4.data_const", write_data, 32'h0000_0104);

    ret_before = m_ret;
    put(5'd7, 2'b00, 32'h7777_7777, 32'h0, 3'd0, 2'd0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk_eq("stall.held", write_data, 32'h0000_0104);
      chk_eq("stall.ret_held", retired, ret_before);
    end
    stall = 1'b0;
    step("stall_release");
    chk_eq("stall.ret_once", retired, ret_before + 32'd1);

    ret_before = m_ret;
    put(5'd9, 2'b00, 32'h9999_9999, 32'h0, 3'd0, 2'd0, 32'h0);
    stall = 1'b1; flush = 1'b1;
    step("flush_stall");
    chk_eq("flush_stall.en", {31'd0, write_en}, 32'd0);
    chk_eq("flush_stall.ret", retired, ret_before + 32'd1);
    idle();
    step("flush_after");

    for (int i = 0; i < 400; i++) begin
      in_valid       = 1'($urandom_range(0, 3) != 0);
      stall          = 1'($urandom_range(0, 3) == 0);
      flush          = 1'($urandom_range(0, 9) == 0);
      in_rd_en       = 1'($urandom_range(0, 4) != 0);
      in_rd_addr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      in_wb_sel      = 2'($urandom);
      in_alu_result  = $urandom;
      in_load_data   = $urandom;
      in_load_funct3 = 3'($urandom);
      in_addr_low    = 2'($urandom);
      in_pc_plus4    = $urandom;
      step("rand");
    end

    idle();
    flush = 1'b1;
    step("drain");
    flush = 1'b0;
    force dut.r_retired = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    step("preload");
    release dut.r_retired;
    put(5'd4, 2'b00, 32'h0000_0042, 32'h0, 3'd0, 2'd0, 32'h0);
    step("wrap_load");
    chk_eq("wrap.before", retired, 32'hFFFF_FFFF);
    idle();
    step("wrap_leave");
    chk_eq("wrap.zero", retired, 32'd0);

    put(5'd3, 2'b00, 32'hCAFE_F00D, 32'h0, 3'd0, 2'd0, 32'h0);
    step("pre_rst");
    chk_eq("pre_rst.en", {31'd0, write_en}, 32'd1);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk_eq("async_rst.en",   {31'd0, write_en}, 32'd0);
    chk_eq("async_rst.data", write_data, 32'd0);
    chk_eq("async_rst.ret",  retired, 32'd0);
    check_all("async_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
